gx_reconfig_rmw_master: RTL
===========================

// Module: gx_reconfig_rmw_master
// PURPOSE
//  Avalon-MM master for the transceiver reconfiguration slave port (11-bit address, 32-bit data, waitrequest).
//  Accepts one register request at a time from GBT bank control logic and issues the bus transfers.
//  RMW op: read register, merge (rd & ~mask) | (data & mask), write back. Read op: read only.
//  Typical users: polarity, loopback and recalibration requests. Sits between the GBT control FSMs and the MGT reconfig port.
// PARAMETERS
//  ADDR_W          11    reconfig address width
//  DATA_W          32    reconfig data width
//  TIMEOUT_CYC     1023  max cycles a transfer may hold waitrequest high; 1..65535
//  SKIP_UNCHANGED  1     1: RMW skips the write when the merged value equals the value read
// PORTS
//  reconfig_clk          in   1       single clock, all logic rising-edge
//  reconfig_reset        in   1       asynchronous, active-high reset
//  req_valid             in   1       request present
//  req_ready             out  1       block idle, request accepted when valid&ready
//  req_op                in   1       0 = RMW, 1 = read only
//  req_addr              in   ADDR_W  target register
//  req_mask              in   DATA_W  bits to modify (RMW)
//  req_data              in   DATA_W  new bit values (RMW)
//  rsp_valid             out  1       1-cycle pulse, response ready
//  rsp_rdata             out  DATA_W  value read from the register (before modification)
//  rsp_error             out  1       valid with rsp_valid; 1 = timeout
//  reconfig_write        out  1       Avalon write
//  reconfig_read         out  1       Avalon read
//  reconfig_address      out  ADDR_W  Avalon address
//  reconfig_writedata    out  DATA_W  Avalon write data
//  reconfig_readdata     in   DATA_W  Avalon read data
//  reconfig_waitrequest  in   1       slave stall
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 except req_ready = 1.
//   - FSM in IDLE; timeout counter 0.
//  FSM: IDLE -> RD -> (MRG) -> WR -> RESP -> IDLE.
//  IDLE
//   - req_ready = 1.
//   - On req_valid, latch op/addr/mask/data, drop req_ready, enter RD the next cycle.
//   - Requests are ignored while not IDLE.
//  RD
//   - reconfig_read = 1; reconfig_address = latched address.
//   - Transfer completes in the cycle with read=1 and waitrequest=0; reconfig_readdata is captured in that cycle.
//   - read drops the next cycle.
//   - Next state: read op -> RESP; RMW -> MRG.
//  MRG
//   - One cycle: merged = (rd & ~mask) | (data & mask).
//   - If SKIP_UNCHANGED and merged == rd, go to RESP with no write; otherwise go to WR.
//  WR
//   - reconfig_write = 1; writedata = merged; address held.
//   - Completes in the cycle with write=1 and waitrequest=0, then go to RESP.
//  RESP
//   - rsp_valid = 1 for one cycle; rsp_rdata = captured read value; rsp_error = 0.
//   - Next cycle IDLE with req_ready = 1.
//  Bus rules:
//   - read and write are never high together.
//   - address and writedata are stable while waitrequest = 1.
//  Latency, waitrequest always low:
//   - read op: accept -> rsp_valid = 3 cycles.
//   - RMW with write: 5 cycles.
//   - RMW, write skipped: 4 cycles.
//  Timeout:
//   - Counter clears on entry to RD/WR and counts each cycle while waitrequest = 1.
//   - When it reaches TIMEOUT_CYC, drop read/write and go to RESP with rsp_error = 1.
//   - rsp_rdata = 0 on a read timeout; it holds the captured value on a write timeout.
//  mask = 0 on RMW: merged == rd, so the write is skipped when SKIP_UNCHANGED = 1.
//  Reset mid-transfer: read/write drop immediately (async); no response is issued for the aborted request.
// TESTING
//  1. Read op addr 0x0A0, slave returns 0x1234_5678, waitrequest low -> one read on 0x0A0, rsp_valid 3 cycles after accept, rsp_rdata 0x1234_5678, error 0.
//  2. RMW addr 0x00A, read 0xFFFF_0000, mask 0x0000_00FF, data 0x0000_00A5 -> write 0xFFFF_00A5 to 0x00A; rsp_rdata 0xFFFF_0000.
//  3. RMW where rd already equals merged, SKIP_UNCHANGED = 1 -> no write pulse; rsp_valid at 4 cycles.
//  4. waitrequest held 7 cycles on read and 3 on write -> address/writedata stable throughout; rsp_error 0; back-to-back requests accepted only when req_ready.
//  5. waitrequest stuck high, TIMEOUT_CYC = 15 -> read drops after 15 stall cycles; rsp_valid with rsp_error = 1, rsp_rdata = 0.
//  6. Assert reconfig_reset during WR stall -> write = 0 at once, req_ready = 1, no rsp_valid; the next request completes normally.

Source files
------------

// File: rtl/gx_reconfig_rmw_master.sv
`default_nettype none
// ============================================================================
//  Module   : gx_reconfig_rmw_master
//  Brief    : Avalon-MM master for the transceiver reconfiguration port.
//             Takes one register request at a time and runs a read or a
//             read-merge-write sequence, with a waitrequest timeout.
//  Revision : 1.0  initial release
// ============================================================================
module gx_reconfig_rmw_master #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYC    = 1023,
    parameter int SKIP_UNCHANGED = 1
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset,
    // request / response side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    // Avalon-MM reconfig master
    output logic              reconfig_write,
    output logic              reconfig_read,
    output logic [ADDR_W-1:0] reconfig_address,
    output logic [DATA_W-1:0] reconfig_writedata,
    input  logic [DATA_W-1:0] reconfig_readdata,
    input  logic              reconfig_waitrequest
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_rd   = 3'd1;
    localparam logic [2:0] c_st_mrg  = 3'd2;
    localparam logic [2:0] c_st_wr   = 3'd3;
    localparam logic [2:0] c_st_resp = 3'd4;

    // 17 bits so that TIMEOUT_CYC = 65535 compares without wrap
    localparam logic [16:0] c_to_lim = 17'(TIMEOUT_CYC);

    logic [2:0]        r_state;
    logic              r_req_ready;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_merged;
    logic              r_err;
    logic [16:0]       r_to_cnt;

    logic [DATA_W-1:0] w_merged;
    logic [16:0]       w_to_next;
    logic              w_to_hit;
    logic              w_skip_en;
    logic              w_skip;

    assign w_merged  = (r_rdata & ~r_mask) | (r_data & r_mask);
    assign w_to_next = r_to_cnt + 17'd1;
    // the stall cycle that brings the count up to the limit ends the transfer
    assign w_to_hit  = reconfig_waitrequest && (w_to_next == c_to_lim);

    generate
        if (SKIP_UNCHANGED != 0) begin : g_skip
            assign w_skip_en = 1'b1;
        end else begin : g_no_skip
            assign w_skip_en = 1'b0;
        end
    endgenerate

    assign w_skip = w_skip_en && (w_merged == r_rdata);

    // Request sequencer: IDLE has an accept phase (ready high) and a launch
    // phase (ready low) so the read starts the cycle after the handshake.
    always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
        if (reconfig_reset) begin
            r_state     <= c_st_idle;
            r_req_ready <= 1'b1;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_mask      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_merged    <= '0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_req_ready) begin
                        if (req_valid) begin
                            r_op        <= req_op;
                            r_addr      <= req_addr;
                            r_mask      <= req_mask;
                            r_data      <= req_data;
                            r_err       <= 1'b0;
                            r_req_ready <= 1'b0;
                        end
                    end else begin
                        r_state  <= c_st_rd;
                        r_to_cnt <= '0;
                    end
                end
                c_st_rd: begin
                    if (!reconfig_waitrequest) begin
                        r_rdata <= reconfig_readdata;
                        r_state <= r_op ? c_st_resp : c_st_mrg;
                    end else if (w_to_hit) begin
                        // a timed-out read reports zero data
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= c_st_resp;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                c_st_mrg: begin
                    r_merged <= w_merged;
                    if (w_skip) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_state  <= c_st_wr;
                        r_to_cnt <= '0;
                    end
                end
                c_st_wr: begin
                    if (!reconfig_waitrequest) begin
                        r_state <= c_st_resp;
                    end else if (w_to_hit) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_resp;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                c_st_resp: begin
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bus strobes decode straight from state so an async reset drops them at once
    assign req_ready          = r_req_ready;
    assign reconfig_read      = (r_state == c_st_rd);
    assign reconfig_write     = (r_state == c_st_wr);
    assign reconfig_address   = r_addr;
    assign reconfig_writedata = r_merged;
    assign rsp_valid          = (r_state == c_st_resp);
    assign rsp_error          = rsp_valid & r_err;
    assign rsp_rdata          = rsp_valid ? r_rdata : '0;

endmodule
`default_nettype wire
